// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - dmem_state_t     : responder FSM state encoding (IDLE=0, BUSY=1, DONE=2)
//   - DMEM_LAT_DEFAULT : default request-to-Done latency in cycles
//   - DMEM_CNT_W       : width of the latency down-counter (covers 1..15)
//   - DMEM_WORD_W      : width of one stored word
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

    localparam int DMEM_LAT_DEFAULT = 4;
    localparam int DMEM_CNT_W       = 4;
    localparam int DMEM_WORD_W      = 16;

endpackage

// File: rtl/dmem_word_array.sv
// dmem_word_array
// Word-addressed backing store: synchronous write, asynchronous read, contents
// are never reset. A dump request prints the written array contents in
// simulation builds only.
// Ports:
//   clk    in   clock, write on posedge
//   we     in   write enable
//   waddr  in   word write address
//   wdata  in   write data
//   raddr  in   word read address
//   rdata  out  read data (combinational from raddr)
//   dump   in   dump request, sampled on posedge
module dmem_word_array
    import dmem_pkg::*;
#(
    parameter int AW = 15
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [DMEM_WORD_W-1:0] wdata,
    input  logic [AW-1:0]          raddr,
    output logic [DMEM_WORD_W-1:0] rdata,
    input  logic                   dump
);

    logic [DMEM_WORD_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (dump) begin
            $display("dmem dump begin");
            for (int i = 0; i < 2**AW; i++) begin
                if (!$isunknown(mem[i])) begin
                    $display("dmem[%h] = %h", i, mem[i]);
                end
            end
            $display("dmem dump end");
        end
    end
`endif

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Responder end of the stalling data-memory handshake. A request (Rd xor Wr)
// seen in IDLE raises Stall in the same cycle, is latched, and completes with
// a one-cycle Done pulse exactly LATENCY cycles after it was presented.
//
// Handshake: the requester presents Rd/Wr/Addr/DataIn and must keep them
// stable while Stall=1. The request is complete in the cycle where Done=1
// (Stall=0 there); the inputs in that cycle are ignored and the next request
// may be presented in the following cycle.
//
// Optional feature (macro DMEM_HIT_REG_EN): one-entry {valid, addr, data}
// register refreshed on every completion; an IDLE read that matches it is
// answered in the same cycle with Done=CacheHit=1 and no stall.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous reset, active low
//   Addr       in   byte address, bit 0 ignored for access
//   DataIn     in   write data
//   Rd / Wr    in   read / write request
//   createdump in   dump the store (honoured in IDLE only)
//   DataOut    out  read data, valid while Done=1
//   Stall      out  requester must hold its request
//   Done       out  completion pulse
//   CacheHit   out  completion served from the hit register
//   err        out  protocol error (Rd&Wr, or odd address), combinational
//   dbg_state  out  current FSM state
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = DMEM_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Stall,
    output logic        Done,
    output logic        CacheHit,
    output logic        err,
    output dmem_state_t dbg_state
);

    localparam int WA = ADDR_W - 1;
    localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(LATENCY - 1);

    dmem_state_t            state;
    logic [DMEM_CNT_W-1:0]  cnt;
    logic                   op_wr;
    logic [WA-1:0]          lat_addr;
    logic [15:0]            lat_data;

    logic                   valid_req;
    logic [WA-1:0]          req_word;
    logic                   hit_now;
    logic                   start;
    logic                   mem_we;
    logic [15:0]            mem_rdata;
    logic [15:0]            hit_rdata;

    assign valid_req = Rd ^ Wr;
    assign req_word  = Addr[ADDR_W-1:1];

`ifdef DMEM_HIT_REG_EN
    logic          hit_valid;
    logic [WA-1:0] hit_addr;
    logic [15:0]   hit_data;

    assign hit_now   = rst && (state == ST_IDLE) && Rd && !Wr &&
                       hit_valid && (hit_addr == req_word);
    assign hit_rdata = hit_data;

    // Refreshed on every completion so it can never hold stale data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_valid <= 1'b0;
            hit_addr  <= '0;
            hit_data  <= '0;
        end else if (state == ST_DONE) begin
            hit_valid <= 1'b1;
            hit_addr  <= lat_addr;
            hit_data  <= op_wr ? lat_data : mem_rdata;
        end
    end
`else
    assign hit_now   = 1'b0;
    assign hit_rdata = 16'h0000;
`endif

    // A hit completes on the spot, so it never starts the FSM.
    assign start = (state == ST_IDLE) && valid_req && !hit_now;

    // Writes commit on the edge leaving DONE; a reset before then discards them.
    assign mem_we = (state == ST_DONE) && op_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_wr    <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_wr    <= Wr;
                        lat_addr <= req_word;
                        lat_data <= DataIn;
                        cnt      <= CNT_LOAD;
                        state    <= (LATENCY == 1) ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Leave when the decremented count reaches zero.
                    cnt <= cnt - 1'b1;
                    if (cnt == DMEM_CNT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    dmem_word_array #(.AW(WA)) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (lat_addr),
        .wdata (lat_data),
        .raddr (lat_addr),
        .rdata (mem_rdata),
        .dump  (createdump && (state == ST_IDLE))
    );

    // Outputs are gated by rst so they drop in the same cycle reset asserts,
    // even while the requester still drives a request.
    always_comb begin
        Stall    = 1'b0;
        Done     = 1'b0;
        CacheHit = 1'b0;
        DataOut  = 16'h0000;
        err      = 1'b0;
        if (rst) begin
            Stall    = start || (state == ST_BUSY);
            Done     = (state == ST_DONE) || hit_now;
            CacheHit = hit_now;
            err      = (Rd && Wr) || ((Rd || Wr) && Addr[0]);
            if ((state == ST_DONE) && !op_wr) begin
                DataOut = mem_rdata;
            end else if (hit_now) begin
                DataOut = hit_rdata;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Randomized and directed bench for dmem_responder. A reference model keeps
// the expected store contents and the one-entry hit register in plain arrays;
// each access is followed cycle by cycle and Stall/Done/CacheHit/err/DataOut
// are compared against the latency the model predicts.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic        createdump;
    logic [15:0] DataOut;
    logic        Stall;
    logic        Done;
    logic        CacheHit;
    logic        err;
    dmem_state_t dbg_state;

    int total;
    int bad;

    // Reference model: word-indexed store and hit entry.
    logic [15:0] mem_model [int];
    bit          hit_v;
    int          hit_a;
    logic [15:0] hit_d;

    dmem_responder #(.ADDR_W(16), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .Addr       (Addr),
        .DataIn     (DataIn),
        .Rd         (Rd),
        .Wr         (Wr),
        .createdump (createdump),
        .DataOut    (DataOut),
        .Stall      (Stall),
        .Done       (Done),
        .CacheHit   (CacheHit),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Rd     = 1'b0;
        Wr     = 1'b0;
        Addr   = 16'h0000;
        DataIn = 16'h0000;
    endtask

    // One full access, checked every cycle until its Done.
    task automatic do_access(input bit wr, input logic [15:0] addr, input logic [15:0] data);
        int          word;
        bit          hit;
        int          exp_lat;
        logic [15:0] exp_data;
        bit          known;
        word  = int'(addr[15:1]);
        hit   = 1'b0;
`ifdef DMEM_HIT_REG_EN
        hit = !wr && hit_v && (hit_a == word);
`endif
        exp_lat  = hit ? 0 : LAT;
        known    = wr || hit || mem_model.exists(word);
        exp_data = 16'h0000;
        if (!wr) begin
            if (hit) exp_data = hit_d;
            else if (mem_model.exists(word)) exp_data = mem_model[word];
        end
        Rd     = !wr;
        Wr     = wr;
        Addr   = addr;
        DataIn = data;
        for (int c = 0; c <= exp_lat; c++) begin
            @(negedge clk);
            total++;
            if (Stall !== (c < exp_lat)) begin
                bad++;
                $display("FAIL stall addr=%h cyc=%0d got=%b exp=%b", addr, c, Stall, (c < exp_lat));
            end
            total++;
            if (Done !== (c == exp_lat)) begin
                bad++;
                $display("FAIL done addr=%h cyc=%0d got=%b exp=%b", addr, c, Done, (c == exp_lat));
            end
            total++;
            if (CacheHit !== (hit && c == exp_lat)) begin
                bad++;
                $display("FAIL cachehit addr=%h cyc=%0d got=%b exp=%b", addr, c, CacheHit, hit);
            end
            if (c == 0) begin
                total++;
                if (err !== addr[0]) begin
                    bad++;
                    $display("FAIL err_odd addr=%h got=%b exp=%b", addr, err, addr[0]);
                end
            end
            if (c == exp_lat && known) begin
                total++;
                if (DataOut !== exp_data) begin
                    bad++;
                    $display("FAIL dataout addr=%h wr=%b got=%h exp=%h", addr, wr, DataOut, exp_data);
                end
            end
            next_cycle();
        end
        if (wr) mem_model[word] = data;
        if (known) begin
            hit_v = 1'b1;
            hit_a = word;
            hit_d = wr ? data : exp_data;
        end else begin
            hit_v = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        createdump = 1'b0;
        rst = 1'b0;
        hit_v = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (Stall !== 1'b0 || Done !== 1'b0 || DataOut !== 16'h0 || err !== 1'b0 || CacheHit !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got stall=%b done=%b data=%h err=%b hit=%b exp all 0",
                     Stall, Done, DataOut, err, CacheHit);
        end
        total++;
        if (dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE);
        end
        rst = 1'b1;
        next_cycle();
        // Give 0x0010 known contents, then clear the hit entry with a reset.
        do_access(1'b1, 16'h0010, 16'hA5A5);
        @(negedge clk);
        rst = 1'b0;
        hit_v = 1'b0;
        next_cycle();
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        do_access(1'b0, 16'h0010, 16'h0000);
    endtask

    task automatic test_write_read();
        do_access(1'b1, 16'h0020, 16'hBEEF);
        do_access(1'b0, 16'h0020, 16'h0000);
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 16'h0002, 16'h1111);
        do_access(1'b1, 16'h0004, 16'h2222);
        do_access(1'b0, 16'h0002, 16'h0000);
        do_access(1'b0, 16'h0004, 16'h0000);
    endtask

    task automatic test_err();
        do_access(1'b1, 16'h0008, 16'h0808);
        do_access(1'b1, 16'h000A, 16'h0A0A);
        Rd   = 1'b1;
        Wr   = 1'b1;
        Addr = 16'h0008;
        DataIn = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (err !== 1'b1 || Stall !== 1'b0 || Done !== 1'b0) begin
                bad++;
                $display("FAIL rdwr_reject cyc=%0d got err=%b stall=%b done=%b exp 1,0,0",
                         c, err, Stall, Done);
            end
            next_cycle();
        end
        idle_inputs();
        // Odd address: err flagged, word 0x0008 returned.
        do_access(1'b0, 16'h0009, 16'h0000);
    endtask

    task automatic test_reset_abort();
        do_access(1'b1, 16'h0030, 16'h5555);
        do_access(1'b1, 16'h0032, 16'h0000);
        Wr     = 1'b1;
        Addr   = 16'h0030;
        DataIn = 16'h1234;
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++;
        if (Stall !== 1'b1) begin
            bad++;
            $display("FAIL busy_stall got=%b exp=1", Stall);
        end
        rst = 1'b0;
        hit_v = 1'b0;
        #1;
        total++;
        if (Stall !== 1'b0 || Done !== 1'b0 || DataOut !== 16'h0 || err !== 1'b0 || CacheHit !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs got stall=%b done=%b data=%h err=%b hit=%b exp all 0",
                     Stall, Done, DataOut, err, CacheHit);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            total++;
            if (Done !== 1'b0) begin
                bad++;
                $display("FAIL aborted_done cyc=%0d got=%b exp=0", c, Done);
            end
            next_cycle();
        end
        do_access(1'b0, 16'h0030, 16'h0000);
    endtask

    task automatic test_hit();
        do_access(1'b1, 16'h0040, 16'h4040);
        do_access(1'b1, 16'h0042, 16'h4242);
        do_access(1'b0, 16'h0040, 16'h0000);
        do_access(1'b0, 16'h0040, 16'h0000);
        // Write to the cached word must refresh the entry.
        do_access(1'b1, 16'h0040, 16'h9999);
        do_access(1'b0, 16'h0040, 16'h0000);
    endtask

    task automatic test_random();
        logic [15:0] pool [8];
        for (int i = 0; i < 8; i++) begin
            pool[i] = 16'h0100 + 16'(2 * i);
            do_access(1'b1, pool[i], 16'($urandom));
        end
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            a = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 5) == 0) a[0] = 1'b1;
            do_access(1'($urandom_range(0, 1)), a, 16'($urandom));
            if ($urandom_range(0, 3) == 0) next_cycle();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_err();
        test_reset_abort();
        test_hit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
